// File: rtl/core_pkg.sv
// Shared core-wide constants: datapath width, default reset vector and the canonical NOP.
package core_pkg;

    localparam int unsigned CORE_XLEN = 32;
    localparam int unsigned ILEN      = 32;

    localparam logic [CORE_XLEN-1:0] CORE_RESET_PC = 32'h0000_0000;
    localparam logic [ILEN-1:0]      NOP_INST      = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with synchronous flush; the caller guarantees no push when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data_out,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~w_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_data_out = r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-limited in-order requests, prefetch queue,
// and redirect handling that flushes the queue and drops stale in-flight responses.
module fetch_unit
    import core_pkg::*;
#(
    parameter int unsigned     XLEN     = CORE_XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(CORE_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int unsigned     CW     = $clog2(DEPTH) + 1;
    localparam int unsigned     IW     = CW + 1;
    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_head_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic [XLEN-1:0] w_redirect_target;
    logic [CW-1:0]   w_count;
    logic [IW-1:0]   w_inflight;
    logic            w_credit;
    logic            w_req_fire;
    logic            w_pop;
    logic            w_push;
    logic            w_drop_rsp;
    logic            w_fifo_empty;
    logic [ILEN-1:0] w_fifo_data;

    assign w_redirect_target = redirect_pc & ~XLEN'(3);

    // Credit counts both queued words and words still in flight, so a push never overflows.
    assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_count};
    assign w_credit   = (w_inflight < IW'(DEPTH));

    assign imem_req_valid = rst & ~redirect_valid & w_credit;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    assign inst_valid = rst & ~redirect_valid & ~w_fifo_empty;
    assign inst_pc    = r_head_pc;
    assign inst_data  = w_fifo_empty ? NOP_INST : w_fifo_data;
    assign w_pop      = inst_valid & inst_ready;

    assign w_drop_rsp = (r_drop_cnt != '0);
    assign w_push     = rst & imem_rsp_valid & ~redirect_valid & ~w_drop_rsp;

    // A redirect discards everything still in flight, including drops owed to earlier redirects.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_head_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= w_redirect_target;
            r_head_pc     <= w_redirect_target;
            r_outstanding <= r_outstanding - CW'(imem_rsp_valid);
            r_drop_cnt    <= r_outstanding - CW'(imem_rsp_valid);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + PC_INC;
            end
            if (w_pop) begin
                r_head_pc <= r_head_pc + PC_INC;
            end
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && w_drop_rsp) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (ILEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (imem_rsp_data),
        .i_pop       (w_pop),
        .o_data_out  (w_fifo_data),
        .o_count     (w_count),
        .o_empty     (w_fifo_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order variable-latency memory plus a queue-based model of the fetch stream.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct packed {
        logic        stale;
        logic [31:0] pc;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    fetch_unit #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          last_due = 0;
    mem_req_t    mq[$];
    pend_t       pend[$];
    logic [31:0] bq[$];
    logic [31:0] m_fetch_pc = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance model and memory.
    task automatic step(input logic rst_i, input logic redir, input logic [31:0] rpc,
                        input logic rq_rdy, input logic in_rdy);
        logic        exp_req;
        logic        exp_inst;
        logic        rsp;
        int          lat;
        int          due;
        pend_t       p;
        @(negedge clk);
        rst            = rst_i;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rq_rdy;
        inst_ready     = in_rdy;
        rsp            = rst_i && (mq.size() != 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
        #1;
        exp_req  = rst_i && !redir && ((pend.size() + bq.size()) < DEPTH);
        exp_inst = rst_i && !redir && (bq.size() != 0);
        check("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) check("req_addr", imem_req_addr, m_fetch_pc);
        check("inst_valid", 32'(inst_valid), 32'(exp_inst));
        if (exp_inst) begin
            check("inst_pc", inst_pc, bq[0]);
            check("inst_data", inst_data, mem_word(bq[0]));
        end

        // memory side, driven by what the DUT actually requested
        if (rsp) void'(mq.pop_front());
        if (!rst_i) begin
            mq.delete();
            last_due = cyc;
        end else if (imem_req_valid && imem_req_ready) begin
            n_acc++;
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: imem_req_addr, due: due});
        end

        // reference model of the fetch stream
        if (!rst_i) begin
            pend.delete();
            bq.delete();
            m_fetch_pc = RESET_PC;
        end else if (redir) begin
            if (rsp && pend.size() != 0) void'(pend.pop_front());
            foreach (pend[i]) pend[i].stale = 1'b1;
            bq.delete();
            m_fetch_pc = {rpc[31:2], 2'b00};
        end else begin
            if (exp_inst && in_rdy) void'(bq.pop_front());
            if (rsp && pend.size() != 0) begin
                p = pend.pop_front();
                if (!p.stale) bq.push_back(p.pc);
            end
            if (exp_req && rq_rdy) begin
                pend.push_back('{stale: 1'b0, pc: m_fetch_pc});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n, input logic rq_rdy, input logic in_rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, rq_rdy, in_rdy);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    initial begin
        // reset, then streaming with single-cycle memory
        lat_min = 1; lat_max = 1;
        do_reset(3);
        run(14, 1'b1, 1'b1);

        // back-pressure: queue fills, exactly DEPTH requests go out
        do_reset(1);
        n_acc = 0;
        run(10, 1'b1, 1'b0);
        check("bp_accepts", 32'(n_acc), 32'(DEPTH));
        run(12, 1'b1, 1'b1);

        // redirect with requests in flight against 3-cycle memory
        lat_min = 3; lat_max = 3;
        do_reset(1);
        run(6, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b1);
        run(12, 1'b1, 1'b1);

        // misaligned target and redirect colliding with a response
        lat_min = 1; lat_max = 1;
        run(4, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0103, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0203, 1'b1, 1'b1);
        run(8, 1'b1, 1'b1);

        // reset mid-stream with requests outstanding
        lat_min = 3; lat_max = 3;
        run(5, 1'b1, 1'b1);
        do_reset(1);
        run(10, 1'b1, 1'b1);

        // PC wrap-around
        lat_min = 1; lat_max = 2;
        step(1'b1, 1'b1, 32'hFFFF_FFF4, 1'b1, 1'b1);
        run(12, 1'b1, 1'b1);

        // randomized traffic
        lat_min = 1; lat_max = 5;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            case ($urandom_range(2, 0))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                default: rpc = $urandom & 32'h0000_0FFF;
            endcase
            step($urandom_range(199, 0) != 0, $urandom_range(11, 0) == 0, rpc,
                 $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
